data_mem_responder: RTL and testbench

- Responder end of the core's load/store memory interface. Accepts single requests carrying direction (mem_dir_e), size (mem_size_e), byte address and write data from the core's memory stage.
- Performs byte-lane-aligned writes into an internal word-organised RAM, and returns load data extended to 32 bits per the size code.
- Inserts programmable wait states and flags illegal accesses.
- Serves as the data-side memory model/slave for the core in simulation and FPGA builds.

---
 rtl/data_mem_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the core's load/store interface.
// Takes one request at a time, waits LATENCY cycles, then performs a
// byte-lane write or an extended read against a word-organised RAM and
// holds the response until the core takes it. Illegal accesses report
// an error and leave the RAM untouched.

module data_mem_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_dir,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    // Wait counter start value; LATENCY is limited to 0..7, so three bits suffice.
    localparam logic [2:0] CNT_START = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_dir_e;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic [2:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH];

    // View of the access being performed. With LATENCY=0 the RAM is touched
    // on the same edge that accepts the request, so the live request inputs
    // are used while still in IDLE; otherwise the captured copy is used.
    logic              acc_dir;
    logic [2:0]        acc_size;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;

    logic              acc_legal;
    logic [31:0]       rd_word;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_val;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic              enter_resp;
    logic              mem_we;

    // Select between live request and captured request for the RAM access.
    always_comb begin
        acc_dir   = dir_q;
        acc_size  = size_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_dir   = req_dir;
            acc_size  = req_size;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    // Legality: alignment per size, unsigned sizes only for loads, reserved codes rejected.
    always_comb begin
        acc_legal = 1'b0;
        case (acc_size)
            SIZE_B:  acc_legal = 1'b1;
            SIZE_H:  acc_legal = (acc_addr[0] == 1'b0);
            SIZE_W:  acc_legal = (acc_addr[1:0] == 2'b00);
            SIZE_BU: acc_legal = (acc_dir == MEM_READ);
            SIZE_HU: acc_legal = (acc_dir == MEM_READ) && (acc_addr[0] == 1'b0);
            default: acc_legal = 1'b0;
        endcase
    end

    // Load path: pick the addressed byte/half from the word and extend it.
    always_comb begin
        rd_word  = mem[acc_addr[ADDR_W-1:2]];
        sel_byte = rd_word[7:0];
        case (acc_addr[1:0])
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = 32'd0;
        case (acc_size)
            SIZE_B:  load_val = {{24{sel_byte[7]}}, sel_byte};
            SIZE_BU: load_val = {24'd0, sel_byte};
            SIZE_H:  load_val = {{16{sel_half[15]}}, sel_half};
            SIZE_HU: load_val = {16'd0, sel_half};
            SIZE_W:  load_val = rd_word;
            default: load_val = 32'd0;
        endcase
    end

    // Store path: replicate right-aligned store data onto every lane and pick byte enables.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = acc_wdata;
        case (acc_size)
            SIZE_B: begin
                wr_be   = 4'b0001 << acc_addr[1:0];
                wr_data = {4{acc_wdata[7:0]}};
            end
            SIZE_H: begin
                wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc_wdata[15:0]}};
            end
            SIZE_W: begin
                wr_be   = 4'b1111;
                wr_data = acc_wdata;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_data = acc_wdata;
            end
        endcase
    end

    // Next-state and capture logic for the IDLE -> WAIT -> RESP handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    dir_d   = req_dir;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_START;
                    end else begin
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            state_d = RESP;
            err_d   = !acc_legal;
            rdata_d = (acc_legal && acc_dir == MEM_READ) ? load_val : 32'd0;
        end
    end

    // Handshake outputs are decoded directly from the state and response registers.
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        mem_we    = enter_resp && rst_n && acc_legal && (acc_dir == MEM_WRITE);
    end

    // Control and response registers; RAM contents deliberately survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            dir_q   <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane RAM write, committed on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (wr_be[0]) mem[acc_addr[ADDR_W-1:2]][7:0]   <= wr_data[7:0];
            if (wr_be[1]) mem[acc_addr[ADDR_W-1:2]][15:8]  <= wr_data[15:8];
            if (wr_be[2]) mem[acc_addr[ADDR_W-1:2]][23:16] <= wr_data[23:16];
            if (wr_be[3]) mem[acc_addr[ADDR_W-1:2]][31:24] <= wr_data[31:24];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: three responders with LATENCY 0, 1 and 3 driven by
// directed and random requests, compared against a word-array memory model.

module tb_data_mem_responder;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_dir   [3];
    logic [2:0]  req_size  [3];
    logic [11:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    logic [31:0] model_mem [3][1024];

    int tests_run;
    int tests_failed;

    data_mem_responder #(.ADDR_W(12), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_dir(req_dir[0]),
        .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.ADDR_W(12), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_dir(req_dir[1]),
        .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    data_mem_responder #(.ADDR_W(12), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_dir(req_dir[2]),
        .req_size(req_size[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lat_of(input int u);
        return (u == 0) ? 0 : ((u == 1) ? 1 : 3);
    endfunction

    // Reference model: legality by size rules, then byte/half arithmetic on a word array
    function automatic void model_access(input int u, input logic dir, input logic [2:0] size,
                                         input logic [11:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] rd, output logic err);
        int          idx;
        int          bo;
        int          hsh;
        logic        legal;
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        idx = int'(addr) / 4;
        bo  = int'(addr) % 4;
        hsh = (bo / 2) * 16;
        w   = model_mem[u][idx];
        case (size)
            3'd0:    legal = 1'b1;
            3'd1:    legal = (bo % 2 == 0);
            3'd2:    legal = (bo == 0);
            3'd4:    legal = (dir == 1'b0);
            3'd5:    legal = (dir == 1'b0) && (bo % 2 == 0);
            default: legal = 1'b0;
        endcase
        rd  = 32'd0;
        err = !legal;
        if (legal && dir) begin
            if (size == 3'd0)
                w = (w & ~(32'hFF << (8 * bo))) | ({24'd0, wdata[7:0]} << (8 * bo));
            else if (size == 3'd1)
                w = (w & ~(32'hFFFF << hsh)) | ({16'd0, wdata[15:0]} << hsh);
            else
                w = wdata;
            model_mem[u][idx] = w;
        end else if (legal) begin
            b = (w >> (8 * bo)) & 32'hFF;
            h = (w >> hsh) & 32'hFFFF;
            case (size)
                3'd0:    rd = b[7] ? (b | 32'hFFFFFF00) : b;
                3'd4:    rd = b;
                3'd1:    rd = h[15] ? (h | 32'hFFFF0000) : h;
                3'd5:    rd = h;
                default: rd = w;
            endcase
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; checks latency, data, error and return to IDLE
    task automatic applyStimulus(input int u, input logic dir, input logic [2:0] size,
                                 input logic [11:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] obs_rdata);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          edges;
        logic        got;
        model_access(u, dir, size, addr, wdata, exp_rd, exp_err);
        checkOutput("ready_before", 32'(req_ready[u]), 32'd1);
        req_dir[u]   = dir;
        req_size[u]  = size;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        rsp_ready[u] = 1'b1;
        req_valid[u] = 1'b1;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk);
            #1;
            if (edges == 0) req_valid[u] = 1'b0;
            edges++;
            @(negedge clk);
            got = rsp_valid[u];
        end
        obs_rdata = rsp_rdata[u];
        checkOutput("latency", 32'(edges), 32'(lat_of(u) + 1));
        checkOutput("rdata", rsp_rdata[u], exp_rd);
        checkOutput("err", 32'(rsp_err[u]), 32'(exp_err));
        @(posedge clk);
        #1;
        checkOutput("valid_after", 32'(rsp_valid[u]), 32'd0);
        checkOutput("ready_after", 32'(req_ready[u]), 32'd1);
    endtask

    task automatic checkResetState(input int u);
        checkOutput("rst_ready", 32'(req_ready[u]), 32'd1);
        checkOutput("rst_valid", 32'(rsp_valid[u]), 32'd0);
        checkOutput("rst_rdata", rsp_rdata[u], 32'd0);
        checkOutput("rst_err", 32'(rsp_err[u]), 32'd0);
    endtask

    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          edges;
    logic        got;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        for (int u = 0; u < 3; u++) begin
            req_valid[u] = 1'b0;
            req_dir[u]   = 1'b0;
            req_size[u]  = 3'd0;
            req_addr[u]  = 12'd0;
            req_wdata[u] = 32'd0;
            rsp_ready[u] = 1'b1;
        end

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) checkResetState(u);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload the test region (words 0..31) of every instance
        for (int u = 0; u < 3; u++)
            for (int w = 0; w < 32; w++)
                applyStimulus(u, 1'b1, SZ_W, 12'(w * 4), $urandom, rd);

        // Basic write/read, LATENCY=1
        applyStimulus(1, 1'b1, SZ_W, 12'h010, 32'hDEADBEEF, rd);
        checkOutput("store_rdata", rd, 32'd0);
        applyStimulus(1, 1'b0, SZ_W, 12'h010, 32'd0, rd);
        checkOutput("load_w", rd, 32'hDEADBEEF);

        // Sub-word extension
        applyStimulus(1, 1'b1, SZ_W, 12'h020, 32'h80F17F05, rd);
        applyStimulus(1, 1'b0, SZ_B,  12'h022, 32'd0, rd); checkOutput("lb_22",  rd, 32'hFFFFFFF1);
        applyStimulus(1, 1'b0, SZ_BU, 12'h022, 32'd0, rd); checkOutput("lbu_22", rd, 32'h000000F1);
        applyStimulus(1, 1'b0, SZ_B,  12'h021, 32'd0, rd); checkOutput("lb_21",  rd, 32'h0000007F);
        applyStimulus(1, 1'b0, SZ_H,  12'h022, 32'd0, rd); checkOutput("lh_22",  rd, 32'hFFFF80F1);
        applyStimulus(1, 1'b0, SZ_HU, 12'h022, 32'd0, rd); checkOutput("lhu_22", rd, 32'h000080F1);
        applyStimulus(1, 1'b0, SZ_H,  12'h020, 32'd0, rd); checkOutput("lh_20",  rd, 32'h00007F05);

        // Partial writes
        applyStimulus(1, 1'b1, SZ_W, 12'h030, 32'h11223344, rd);
        applyStimulus(1, 1'b1, SZ_B, 12'h031, 32'h000000AA, rd);
        applyStimulus(1, 1'b0, SZ_W, 12'h030, 32'd0, rd); checkOutput("sb_31", rd, 32'h1122AA44);
        applyStimulus(1, 1'b1, SZ_H, 12'h032, 32'h0000BEEF, rd);
        applyStimulus(1, 1'b0, SZ_W, 12'h030, 32'd0, rd); checkOutput("sh_32", rd, 32'hBEEFAA44);

        // Illegal accesses leave RAM untouched
        applyStimulus(1, 1'b1, SZ_W, 12'h040, 32'hCAFEF00D, rd);
        applyStimulus(1, 1'b0, SZ_W,   12'h041, 32'd0, rd);
        applyStimulus(1, 1'b1, SZ_H,   12'h043, 32'h00001234, rd);
        applyStimulus(1, 1'b1, SZ_BU,  12'h040, 32'h00000055, rd);
        applyStimulus(1, 1'b0, 3'b111, 12'h040, 32'd0, rd);
        applyStimulus(1, 1'b1, 3'b011, 12'h040, 32'h99999999, rd);
        applyStimulus(1, 1'b0, SZ_W,   12'h040, 32'd0, rd); checkOutput("err_unchanged", rd, 32'hCAFEF00D);

        // Backpressure on LATENCY=3, with an ignored request pulse while holding the response
        model_access(2, 1'b0, SZ_W, 12'h010, 32'd0, exp_rd, exp_err);
        req_dir[2]   = 1'b0;
        req_size[2]  = SZ_W;
        req_addr[2]  = 12'h010;
        rsp_ready[2] = 1'b0;
        req_valid[2] = 1'b1;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk);
            #1;
            if (edges == 0) req_valid[2] = 1'b0;
            edges++;
            @(negedge clk);
            got = rsp_valid[2];
        end
        checkOutput("bp_latency", 32'(edges), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                req_dir[2]   = 1'b1;
                req_size[2]  = SZ_W;
                req_addr[2]  = 12'h010;
                req_wdata[2] = 32'h55AA55AA;
                req_valid[2] = 1'b1;
            end
            if (i == 2) req_valid[2] = 1'b0;
            @(negedge clk);
            checkOutput("bp_valid", 32'(rsp_valid[2]), 32'd1);
            checkOutput("bp_rdata", rsp_rdata[2], exp_rd);
            checkOutput("bp_ready", 32'(req_ready[2]), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready[2] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", 32'(rsp_valid[2]), 32'd0);
        checkOutput("bp_release_ready", 32'(req_ready[2]), 32'd1);
        applyStimulus(2, 1'b0, SZ_W, 12'h010, 32'd0, rd);
        checkOutput("bp_ignored", rd, exp_rd);

        // Reset during WAIT abandons the write
        applyStimulus(2, 1'b1, SZ_W, 12'h050, 32'h00000000, rd);
        req_dir[2]   = 1'b1;
        req_size[2]  = SZ_W;
        req_addr[2]  = 12'h050;
        req_wdata[2] = 32'h12345678;
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState(2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(2, 1'b0, SZ_W, 12'h050, 32'd0, rd);
        checkOutput("rst_no_write", rd, 32'h00000000);

        // Random traffic across all three latencies
        for (int n = 0; n < 300; n++) begin
            applyStimulus($urandom_range(0, 2), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          12'($urandom_range(0, 127)), $urandom, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
